mdu_seq_ctrl: RTL

Iterative multiply/divide sequencer for the CPU datapath. It accepts a MUL/DIV request from the decode/ALU-control stage and runs a shift-add multiply or restoring divide over WIDTH cycles. It holds `busy_o` so the pipeline stalls, then publishes the 2·WIDTH-bit result on the HI/LO registers. It offloads the multi-cycle operations that the single-cycle ALU cannot complete in one cycle.

---
 rtl/mdu_seq_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mdu_seq_ctrl.sv
// Iterative shift-add multiplier / restoring divider that publishes a 2*WIDTH result on HI/LO.
// Optional divider datapath: define MDU_SEQ_DIV_EN to build it; otherwise DIVU/DIV complete at once with HI/LO untouched.
module mdu_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   opd_q, opd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               neg_lo_q, neg_lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic               s1_neg, s2_neg, last_iter;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] step, prod_fix;
`ifdef MDU_SEQ_DIV_EN
    logic               is_div_q, is_div_d;
    logic               neg_hi_q, neg_hi_d;
    logic [WIDTH:0]     div_rs;
    logic [WIDTH+1:0]   div_diff;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
`endif

    assign s1_neg    = op_i[0] & src1_i[WIDTH-1];
    assign s2_neg    = op_i[0] & src2_i[WIDTH-1];
    assign mag1      = s1_neg ? -src1_i : src1_i;
    assign mag2      = s2_neg ? -src2_i : src2_i;
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    // One iteration of the active algorithm, plus its sign-corrected form for the final step.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
        step    = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef MDU_SEQ_DIV_EN
        div_rs   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = {1'b0, div_rs} - {2'b00, opd_q};
        if (is_div_q) begin
            if (!div_diff[WIDTH+1])
                step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else
                step = {div_rs[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
        quo_fix = neg_lo_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
        rem_fix = neg_hi_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
`endif
        prod_fix = neg_lo_q ? -step : step;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
`ifdef MDU_SEQ_DIV_EN
                    state_d = S_RUN;
`else
                    state_d = op_i[1] ? S_DONE : S_RUN;
`endif
                end
            end
            S_RUN:   if (last_iter) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        opd_d    = opd_q;
        acc_d    = acc_q;
        neg_lo_d = neg_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        busy_d   = (state_d != S_IDLE);
`ifdef MDU_SEQ_DIV_EN
        is_div_d = is_div_q;
        neg_hi_d = neg_hi_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    cnt_d = '0;
`ifdef MDU_SEQ_DIV_EN
                    is_div_d = op_i[1];
                    neg_hi_d = s1_neg;
                    if (op_i[1]) begin
                        // Division by zero keeps the quotient all ones: only the remainder is sign-corrected.
                        acc_d    = {{WIDTH{1'b0}}, mag1};
                        opd_d    = mag2;
                        neg_lo_d = (s1_neg ^ s2_neg) & (|src2_i);
                    end else
`endif
                    begin
                        acc_d    = {{WIDTH{1'b0}}, mag2};
                        opd_d    = mag1;
                        neg_lo_d = s1_neg ^ s2_neg;
                    end
`ifndef MDU_SEQ_DIV_EN
                    done_d = op_i[1];
`endif
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
                acc_d = step;
                if (last_iter) begin
                    done_d = 1'b1;
`ifdef MDU_SEQ_DIV_EN
                    if (is_div_q) {hi_d, lo_d} = {rem_fix, quo_fix};
                    else
`endif
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            opd_q    <= '0;
            acc_q    <= '0;
            neg_lo_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef MDU_SEQ_DIV_EN
            is_div_q <= 1'b0;
            neg_hi_q <= 1'b0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            opd_q    <= opd_d;
            acc_q    <= acc_d;
            neg_lo_q <= neg_lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
`ifdef MDU_SEQ_DIV_EN
            is_div_q <= is_div_d;
            neg_hi_q <= neg_hi_d;
`endif
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
endmodule
